// File: rtl/spart_pkg.sv
// Shared types and constants for the SPART serial port.
package spart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  localparam int unsigned OVERSAMPLE   = 16;
  localparam int unsigned DATA_BITS    = 8;
  localparam int unsigned START_SAMPLE = 8;

endpackage

// File: rtl/spart_brg_tick.sv
// Baud-rate oversample tick generator: one tick every brg_div+1 clocks.
module spart_brg_tick (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] brg_div,
  input  logic        restart,
  output logic        tick
);

  logic [15:0] cnt_q;

  // Reloading from the live divisor keeps the counter bounded if brg_div changes mid-count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (restart || cnt_q == '0) begin
      cnt_q <= brg_div;
    end else begin
      cnt_q <= cnt_q - 16'd1;
    end
  end

  assign tick = (cnt_q == '0) && !restart;

endmodule

// File: rtl/spart_rx.sv
// SPART receiver: 16x oversampled 8N1 deserializer with a one-byte buffer and status flags.
module spart_rx #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  input  logic [15:0]          brg_div,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rda,
  output logic                 framing_err,
  output logic                 overrun
);

  import spart_pkg::*;

  rx_state_t            state_q, state_d;
  logic                 sync1_q, rxs;
  logic [3:0]           tick_cnt_q, tick_cnt_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tick, restart, commit, stop_bit;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      sync1_q <= rxd;
      rxs     <= sync1_q;
    end
  end

  spart_brg_tick u_brg (
    .clk     (clk),
    .rst     (rst),
    .brg_div (brg_div),
    .restart (restart),
    .tick    (tick)
  );

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    restart    = 1'b0;
    commit     = 1'b0;
    stop_bit   = 1'b1;
    case (state_q)
      IDLE: begin
        if (!rxs) begin
          restart    = 1'b1;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = START;
        end
      end
      START: begin
        if (tick) begin
          if (tick_cnt_q == 4'(START_SAMPLE - 1)) begin
            tick_cnt_d = '0;
            state_d    = rxs ? IDLE : DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tick_cnt_q == 4'(OVERSAMPLE - 1)) begin
            tick_cnt_d = '0;
            shift_d    = {rxs, shift_q[DATA_BITS-1:1]};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
              state_d = STOP;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (tick_cnt_q == 4'(OVERSAMPLE - 1)) begin
            tick_cnt_d = '0;
            commit     = 1'b1;
            stop_bit   = rxs;
            // A low stop bit means the line may be held in break; wait for it to recover.
            state_d    = rxs ? IDLE : BREAK;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      BREAK: begin
        if (rxs) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
    end
  end

  // A read in the commit cycle frees the buffer, so the new byte lands without an overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data     <= '0;
      rda         <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else if (commit) begin
      if (!rda || rd_en) begin
        rx_data     <= shift_q;
        rda         <= 1'b1;
        framing_err <= !stop_bit;
      end else begin
        overrun <= 1'b1;
      end
    end else if (rd_en && rda) begin
      rda         <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spart_rx.sv
// Directed bench for spart_rx at brg_div=3 (64 clocks per bit).
module tb_spart_rx;
  import spart_pkg::*;

  localparam int BIT_CLKS = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        rxd;
  logic [15:0] brg_div;
  logic        rd_en;
  logic [7:0]  rx_data;
  logic        rda;
  logic        framing_err;
  logic        overrun;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int commits = 0;
  int start_cyc;
  int base;
  int lat;
  logic rda_prev = 1'b0;

  spart_rx dut (
    .clk         (clk),
    .rst         (rst),
    .rxd         (rxd),
    .brg_div     (brg_div),
    .rd_en       (rd_en),
    .rx_data     (rx_data),
    .rda         (rda),
    .framing_err (framing_err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rda && !rda_prev) begin
      rise_cyc = cyc;
      commits  = commits + 1;
    end
    rda_prev = rda;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_clks(BIT_CLKS);
    end
    rxd = stop;
    wait_clks(BIT_CLKS);
  endtask

  task automatic pulse_rd();
    rd_en = 1'b1;
    wait_clks(1);
    rd_en = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    rxd     = 1'b1;
    rd_en   = 1'b0;
    brg_div = 16'd3;
    wait_clks(5);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rda", rda, 1'b0);
    check("reset_ferr", framing_err, 1'b0);
    check("reset_overrun", overrun, 1'b0);
    rst = 1'b0;
    wait_clks(20);

    // 1: single byte and latency
    start_cyc = cyc;
    send_frame(8'hA5, 1'b1);
    lat = rise_cyc - start_cyc;
    total++;
    assert (lat >= 609 && lat <= 613) else begin
      bad++;
      $error("FAIL latency: observed=%0d expected=611+-2", lat);
    end
    check("t1_rda", rda, 1'b1);
    check("t1_data", rx_data, 8'hA5);
    check("t1_ferr", framing_err, 1'b0);
    check("t1_overrun", overrun, 1'b0);
    pulse_rd();
    check("t1_rda_cleared", rda, 1'b0);
    wait_clks(10);

    // 2: glitch then valid frame
    rxd = 1'b0;
    wait_clks(16);
    rxd = 1'b1;
    wait_clks(100);
    check("t2_glitch_rda", rda, 1'b0);
    check("t2_glitch_idle", dut.state_q, IDLE);
    send_frame(8'h3C, 1'b1);
    check("t2_rda", rda, 1'b1);
    check("t2_data", rx_data, 8'h3C);
    check("t2_ferr", framing_err, 1'b0);
    pulse_rd();
    wait_clks(10);

    // 3: framing error with held-low line
    base = commits;
    send_frame(8'h81, 1'b0);
    wait_clks(200);
    check("t3_rda", rda, 1'b1);
    check("t3_data", rx_data, 8'h81);
    check("t3_ferr", framing_err, 1'b1);
    check("t3_overrun_low", overrun, 1'b0);
    check("t3_one_commit", commits - base, 1);
    rxd = 1'b1;
    wait_clks(100);
    check("t3_overrun_after", overrun, 1'b0);
    check("t3_idle", dut.state_q, IDLE);
    pulse_rd();
    check("t3_ferr_cleared", framing_err, 1'b0);
    wait_clks(10);

    // 4: overrun
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    wait_clks(50);
    check("t4_rda", rda, 1'b1);
    check("t4_data", rx_data, 8'h11);
    check("t4_overrun", overrun, 1'b1);
    pulse_rd();
    check("t4_rda_clr", rda, 1'b0);
    check("t4_overrun_clr", overrun, 1'b0);
    check("t4_ferr_clr", framing_err, 1'b0);
    wait_clks(10);

    // 5: read in the exact commit cycle of the second byte
    send_frame(8'h55, 1'b1);
    check("t5_first_data", rx_data, 8'h55);
    fork
      send_frame(8'hAA, 1'b1);
      begin
        wait_clks(610);
        pulse_rd();
      end
    join
    check("t5_data", rx_data, 8'hAA);
    check("t5_rda", rda, 1'b1);
    check("t5_overrun", overrun, 1'b0);
    wait_clks(10);

    // 6: reset during data bit 4 of 0xF0
    base = commits;
    fork
      send_frame(8'hF0, 1'b1);
      begin
        wait_clks(330);
        rst = 1'b1;
        wait_clks(4);
        check("t6_rst_data", rx_data, 8'h00);
        check("t6_rst_rda", rda, 1'b0);
        check("t6_rst_ferr", framing_err, 1'b0);
        check("t6_rst_overrun", overrun, 1'b0);
        check("t6_rst_state", dut.state_q, IDLE);
        rst = 1'b0;
      end
    join
    wait_clks(100);
    check("t6_no_commit", commits - base, 0);
    check("t6_rda_low", rda, 1'b0);
    send_frame(8'h0F, 1'b1);
    check("t6_rda", rda, 1'b1);
    check("t6_data", rx_data, 8'h0F);
    check("t6_ferr", framing_err, 1'b0);
    check("t6_overrun", overrun, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
